// File: rtl/ins_cache_lines_r32i.sv
// Direct-mapped multi-line RV32I instruction cache; each miss refills only its own line from instruction RAM.
// Define INS_CACHE_STATS_EN to add the HitCount/MissCount statistics ports.
module ins_cache_lines_r32i #(
  parameter int dataW     = 32,
  parameter int Lines     = 8,
  parameter int LineWords = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic             MemReadReq,
  output logic [dataW-1:0] MemReadAddr,
  input  logic             MemReadValid,
  input  logic [dataW-1:0] MemReadData,
  output logic             InsCacheStall,
  output logic [dataW-1:0] OutputIns
`ifdef INS_CACHE_STATS_EN
  ,
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount
`endif
);

  localparam int OffW = $clog2(LineWords);
  localparam int IdxW = $clog2(Lines);
  localparam int LoW  = 2 + OffW;
  localparam int TagW = dataW - LoW - IdxW;
  localparam int LineW = dataW - LoW;
  localparam logic [dataW-1:0] Nop = dataW'(32'h00000013);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state;
  logic [Lines-1:0] validBits;
  logic [TagW-1:0]  tagMem [Lines];
  logic [dataW-1:0] lineData [Lines][LineWords];
  logic [LineW-1:0] fillLine;
  logic [OffW-1:0]  fillWord;

  logic [OffW-1:0]  offset;
  logic [IdxW-1:0]  index;
  logic [TagW-1:0]  tag;
  logic [IdxW-1:0]  fillIdx;
  logic [TagW-1:0]  fillTag;
  logic             hit;
  logic             inRun;
  logic             lastWord;
  logic             accept;
  logic             unusedAddrBits;

  assign offset         = ProgAddr[LoW-1:2];
  assign index          = ProgAddr[LoW+IdxW-1:LoW];
  assign tag            = ProgAddr[dataW-1:LoW+IdxW];
  assign unusedAddrBits = ^ProgAddr[1:0];

  assign fillIdx  = fillLine[IdxW-1:0];
  assign fillTag  = fillLine[LineW-1:IdxW];
  assign inRun    = (state == RUN);
  assign hit      = validBits[index] && (tagMem[index] == tag);
  assign lastWord = (fillWord == OffW'(LineWords - 1));
  assign accept   = (state == FILL) && MemReadValid && !Flush;

  // The CPU only sees a real instruction on a RUN-state hit; everything else is a stalled NOP.
  always_comb begin
    InsCacheStall = 1'b1;
    OutputIns     = Nop;
    if (inRun && hit) begin
      InsCacheStall = 1'b0;
      OutputIns     = lineData[index][offset];
    end
  end

  // Control state. Flush wins over everything, including starting a fill and completing one.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= RUN;
      validBits   <= '0;
      fillLine    <= '0;
      fillWord    <= '0;
      MemReadReq  <= 1'b0;
      MemReadAddr <= '0;
    end else if (Flush) begin
      state      <= RUN;
      validBits  <= '0;
      fillWord   <= '0;
      MemReadReq <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!hit) begin
            state       <= FILL;
            fillLine    <= ProgAddr[dataW-1:LoW];
            fillWord    <= '0;
            MemReadReq  <= 1'b1;
            MemReadAddr <= {ProgAddr[dataW-1:LoW], LoW'(0)};
          end
        end
        FILL: begin
          if (MemReadValid) begin
            fillWord <= fillWord + OffW'(1);
            if (lastWord) begin
              validBits[fillIdx] <= 1'b1;
              state              <= RUN;
              MemReadReq         <= 1'b0;
            end else begin
              validBits[fillIdx] <= 1'b0;
              MemReadAddr        <= MemReadAddr + dataW'(4);
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Line storage and tags carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clock) begin
    if (accept) begin
      lineData[fillIdx][fillWord] <= MemReadData;
      if (lastWord) begin
        tagMem[fillIdx] <= fillTag;
      end
    end
  end

`ifdef INS_CACHE_STATS_EN
  // Counters free-run and wrap; Flush deliberately leaves them alone.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (inRun && hit) begin
        HitCount <= HitCount + 32'd1;
      end
      if (inRun && !hit && !Flush) begin
        MissCount <= MissCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ins_cache_lines_r32i.sv
// Scoreboard bench for ins_cache_lines_r32i: stimulus queues expected fetch data and RAM addresses, a monitor pops and compares.
// Build with INS_CACHE_STATS_EN defined to also exercise the hit/miss counters.
module tb_ins_cache_lines_r32i;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clock;
  logic        resetN;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic        MemReadReq;
  logic [31:0] MemReadAddr;
  logic        MemReadValid;
  logic [31:0] MemReadData;
  logic        InsCacheStall;
  logic [31:0] OutputIns;
`ifdef INS_CACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] expQ[$];
  logic [31:0] reqQ[$];

  logic memAlt = 1'b0;
  logic memPhase = 1'b0;

  ins_cache_lines_r32i dut (
    .clock        (clock),
    .resetN       (resetN),
    .ProgAddr     (ProgAddr),
    .Flush        (Flush),
    .MemReadReq   (MemReadReq),
    .MemReadAddr  (MemReadAddr),
    .MemReadValid (MemReadValid),
    .MemReadData  (MemReadData),
    .InsCacheStall(InsCacheStall),
    .OutputIns    (OutputIns)
`ifdef INS_CACHE_STATS_EN
    ,
    .HitCount     (HitCount),
    .MissCount    (MissCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM image: each word encodes its own address so misplaced words are obvious.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[19:0], 12'h093};
  endfunction

  assign MemReadData = memWord(MemReadAddr);

  // RAM responder: always ready, or ready on alternate FILL cycles starting with a wait cycle.
  always @(posedge clock) begin
    #1;
    if (!memAlt) begin
      MemReadValid = 1'b1;
      memPhase     = 1'b0;
    end else if (!MemReadReq) begin
      MemReadValid = 1'b0;
      memPhase     = 1'b0;
    end else begin
      MemReadValid = memPhase;
      memPhase     = !memPhase;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Monitor: pops an expected instruction whenever the cache stops stalling and checks every RAM request.
  always @(negedge clock) begin
    if (resetN) begin
      if (!InsCacheStall) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedOutput actual=%h required=stall", OutputIns);
        end else begin
          checkOutput("fetchData", OutputIns, expQ.pop_front());
        end
      end
      if (MemReadReq) begin
        if (reqQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedReq actual=%h required=noRequest", MemReadAddr);
        end else if (MemReadValid) begin
          checkOutput("memAddr", MemReadAddr, reqQ.pop_front());
        end else begin
          checkOutput("memAddrHold", MemReadAddr, reqQ[0]);
        end
      end
    end
  end

  task automatic pushLine(input logic [31:0] base);
    for (int w = 0; w < 4; w++) reqQ.push_back(base + 32'(4 * w));
  endtask

  // Issue one fetch at posedge+1 and count stall cycles until the instruction appears.
  task automatic applyStimulus(input logic [31:0] addr, input int expStall);
    int stalls = 0;
    expQ.push_back(memWord(addr));
    ProgAddr = addr;
    forever begin
      @(negedge clock);
      if (!InsCacheStall) break;
      stalls++;
      if (stalls > 40) break;
    end
    checkOutput($sformatf("stallCycles@%h", addr), 32'(stalls), 32'(expStall));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN       = 1'b0;
    Flush        = 1'b0;
    ProgAddr     = 32'h100;
    MemReadValid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetStall", 32'(InsCacheStall), 32'd1);
    checkOutput("resetIns", OutputIns, Nop);
    checkOutput("resetReq", 32'(MemReadReq), 32'd0);
    checkOutput("resetAddr", MemReadAddr, 32'd0);

    // Cold miss out of reset, then hits across the line
    resetN = 1'b1;
    pushLine(32'h100);
    applyStimulus(32'h100, 5);
    applyStimulus(32'h104, 0);
    applyStimulus(32'h108, 0);
`ifdef INS_CACHE_STATS_EN
    checkOutput("missCount", MissCount, 32'd1);
    checkOutput("hitCount", HitCount, 32'd3);
`endif
    applyStimulus(32'h10C, 0);

    // Conflict eviction on index 0
    pushLine(32'h180);
    applyStimulus(32'h180, 5);
    applyStimulus(32'h184, 0);
    pushLine(32'h100);
    applyStimulus(32'h100, 5);

    // Slow RAM into index 1
    memAlt = 1'b1;
    pushLine(32'h210);
    applyStimulus(32'h210, 9);
    memAlt = 1'b0;
    applyStimulus(32'h21C, 0);

    // Flush on the second accepted word aborts the fill, which then restarts from word 0
    reqQ.push_back(32'h300);
    reqQ.push_back(32'h304);
    ProgAddr = 32'h300;
    @(posedge clock); #1;
    @(posedge clock); #1;
    Flush = 1'b1;
    @(posedge clock); #1;
    Flush = 1'b0;
    checkOutput("flushReq", 32'(MemReadReq), 32'd0);
    checkOutput("flushStall", 32'(InsCacheStall), 32'd1);
    pushLine(32'h300);
    applyStimulus(32'h300, 5);

    // Asynchronous reset mid-fill
    reqQ.push_back(32'h400);
    ProgAddr = 32'h400;
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetN = 1'b0;
    #1;
    checkOutput("asyncResetReq", 32'(MemReadReq), 32'd0);
    checkOutput("asyncResetIns", OutputIns, Nop);
    ProgAddr = 32'h214;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    pushLine(32'h210);
    applyStimulus(32'h214, 5);

    checkOutput("expQEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("reqQEmpty", 32'(reqQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
